// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator at the head of IF.
//
// Purpose:
//   Chooses the next fetch address from one of these sources:
//     - exception vector
//     - EX-stage redirect
//     - stall hold
//     - call target
//     - return prediction, from a circular return-address stack (RAS)
//     - sequential increment
//   PCResult is registered, so no input reaches it combinationally.
//
// Ports:
//   Clk             rising-edge clock
//   Reset           synchronous reset, active low
//   Stall           hold PC; gates sequential/Call/Ret only
//   ExcValid        load EXC_VEC (highest priority)
//   Redirect        load RedirectTarget
//   RedirectTarget  redirect destination
//   Call            push PC+INC, load CallTarget
//   CallTarget      call destination
//   Ret             pop RAS top, or use RetTarget if the RAS is empty
//   RetTarget       fallback return destination
//   PCResult        current fetch PC
//   RasCount        number of valid RAS entries
//   RasEmpty        RasCount == 0
//   RasFull         RasCount == RAS_DEPTH
//   MisalignErr     one-cycle flag after a misaligned redirect/call trap
//
// Build option:
//   PC_MISALIGN_TRAP_EN
//     Traps redirect/call targets that are not INC-aligned to EXC_VEC.
//     When this macro is undefined, MisalignErr is tied to 0.
module pc_gen #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VEC = 32'h00000000,
  parameter logic [WIDTH-1:0]   EXC_VEC   = 32'h00000080,
  parameter int                 INC       = 4,
  parameter int                 RAS_DEPTH = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Stall,
  input  logic                           ExcValid,
  input  logic                           Redirect,
  input  logic [WIDTH-1:0]               RedirectTarget,
  input  logic                           Call,
  input  logic [WIDTH-1:0]               CallTarget,
  input  logic                           Ret,
  input  logic [WIDTH-1:0]               RetTarget,
  output logic [WIDTH-1:0]               PCResult,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount,
  output logic                           RasEmpty,
  output logic                           RasFull,
  output logic                           MisalignErr
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);

  logic [WIDTH-1:0] pc, pc_nxt, pc_seq;
  logic [PW-1:0]    ptr, ptr_inc, ptr_dec;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             empty_q, full_q;
  logic             push, pop;
  logic [WIDTH-1:0] ras [RAS_DEPTH];

  assign pc_seq  = pc + WIDTH'(INC);
  assign ptr_inc = ptr + PW'(1);
  assign ptr_dec = ptr - PW'(1);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [WIDTH-1:0] AMASK = WIDTH'(INC - 1);
  logic trap, merr_q;
`endif

  // Next-PC select, highest priority first.
  always_comb begin
    pc_nxt = pc_seq;
    push   = 1'b0;
    pop    = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    trap   = 1'b0;
`endif
    if (ExcValid) begin
      pc_nxt = EXC_VEC;
    end else if (Redirect) begin
      pc_nxt = RedirectTarget;
`ifdef PC_MISALIGN_TRAP_EN
      if ((RedirectTarget & AMASK) != '0) begin
        pc_nxt = EXC_VEC;
        trap   = 1'b1;
      end
`endif
    end else if (Stall) begin
      pc_nxt = pc;
    end else if (Call) begin
      pc_nxt = CallTarget;
      push   = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
      // A trapping call never reaches its target, so nothing is pushed.
      if ((CallTarget & AMASK) != '0) begin
        pc_nxt = EXC_VEC;
        push   = 1'b0;
        trap   = 1'b1;
      end
`endif
    end else if (Ret) begin
      if (cnt != '0) begin
        pc_nxt = ras[ptr];
        pop    = 1'b1;
      end else begin
        pc_nxt = RetTarget;
      end
    end
  end

  // Count saturates on push-when-full: the pointer wraps over the oldest entry.
  always_comb begin
    cnt_nxt = cnt;
    if (push && cnt != CW'(RAS_DEPTH)) cnt_nxt = cnt + CW'(1);
    else if (pop)                      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc      <= RESET_VEC;
      ptr     <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      cnt     <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      full_q  <= (cnt_nxt == CW'(RAS_DEPTH));
      if (push)     ptr <= ptr_inc;
      else if (pop) ptr <= ptr_dec;
    end
  end

  // Stack contents need no reset; the count qualifies them.
  always_ff @(posedge Clk) begin
    if (Reset && push) ras[ptr_inc] <= pc_seq;
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge Clk) begin
    if (!Reset) merr_q <= 1'b0;
    else        merr_q <= trap;
  end
  assign MisalignErr = merr_q;
`else
  assign MisalignErr = 1'b0;
`endif

  assign PCResult = pc;
  assign RasCount = cnt;
  assign RasEmpty = empty_q;
  assign RasFull  = full_q;

endmodule
